// File: rtl/chan_pkg.sv
// ============================================================================
// Module      : chan_pkg
// Description : Shared types and constants for the channel output path
//               (frame FSM state, default header byte, CRC-8 polynomial,
//               channel count).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package chan_pkg;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_D0  = 2'd1,
    S_D1  = 2'd2,
    S_CRC = 2'd3
  } frame_state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam logic [7:0] CRC8_POLY      = 8'h07;
  localparam int         NUM_CH         = 12;

endpackage

`default_nettype wire

// File: rtl/crc8_byte.sv
// ============================================================================
// Module      : crc8_byte
// Description : Combinational single-byte CRC-8 update (MSB-first, no
//               reflection, no final XOR). Shared by receive and transmit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc8_byte
  import chan_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  // Fold the byte into the running CRC, one polynomial step per bit
  always_comb begin
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

`default_nettype wire

// File: rtl/channel_frame_sequencer.sv
// ============================================================================
// Module      : channel_frame_sequencer
// Description : Assembles 4-byte command frames (HEADER, D0, D1, CRC) from
//               the UART byte stream, stages the 12-bit channel pattern in a
//               shadow register and commits it to ch_out on the rising edge
//               of sync_in. Provides need_data / incorrect_data handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module channel_frame_sequencer
  import chan_pkg::*;
#(
  parameter logic [7:0]        HEADER         = HEADER_DEFAULT,
  parameter int unsigned       TIMEOUT_CYCLES = 5_000_000,
  parameter logic [NUM_CH-1:0] CH_RESET       = 12'h000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              sync_in,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic              rx_error,
  output logic [NUM_CH-1:0] ch_out,
  output logic              need_data,
  output logic              incorrect_data,
  output logic              frame_ok
);

  localparam int            TW     = $clog2(TIMEOUT_CYCLES + 1);
  // Timer value seen on the last idle cycle before the abort fires
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT_CYCLES);

  frame_state_t      state, state_next;
  logic [TW-1:0]     timer;
  logic [7:0]        crc_q, crc_seed, crc_step;
  logic [7:0]        d0_q, d1_q;
  logic [NUM_CH-1:0] shadow, ch_next, pattern;
  logic              pending, pending_next;
  logic              sync_prev, sync_edge;
  logic              byte_ok, timeout, frame_good, frame_bad, abort_err;

  assign byte_ok   = rx_valid && !rx_error;
  assign sync_edge = sync_in && !sync_prev;
  assign pattern   = {d1_q[3:0], d0_q};
  // A header byte restarts the CRC from zero
  assign crc_seed  = (state == S_HDR) ? 8'h00 : crc_q;

  crc8_byte u_crc (
    .crc_in  (crc_seed),
    .data    (rx_byte),
    .crc_out (crc_step)
  );

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_HDR;
    else     state <= state_next;
  end

  // Next state, frame verdict and abort detection; rx_error outranks all
  always_comb begin
    state_next = state;
    frame_good = 1'b0;
    frame_bad  = 1'b0;
    abort_err  = 1'b0;
    timeout    = (state != S_HDR) && !rx_valid && (timer == T_LAST);
    if (rx_error) begin
      state_next = S_HDR;
      abort_err  = (state != S_HDR);
    end else if (timeout) begin
      state_next = S_HDR;
      abort_err  = 1'b1;
    end else if (rx_valid) begin
      case (state)
        S_HDR: if (rx_byte == HEADER) state_next = S_D0;
        S_D0:  state_next = S_D1;
        S_D1:  state_next = S_CRC;
        S_CRC: begin
          state_next = S_HDR;
          if ((rx_byte == crc_q) && (d1_q[7:4] == 4'h0)) frame_good = 1'b1;
          else                                          frame_bad  = 1'b1;
        end
        default: state_next = S_HDR;
      endcase
    end
  end

  // Commit decision: a frame landing on a sync edge bypasses the shadow stage
  always_comb begin
    ch_next      = ch_out;
    pending_next = pending;
    if (frame_good && sync_edge) begin
      ch_next      = pattern;
      pending_next = 1'b0;
    end else if (frame_good) begin
      pending_next = 1'b1;
    end else if (sync_edge && pending) begin
      ch_next      = shadow;
      pending_next = 1'b0;
    end
  end

  // Inter-byte timer: held at zero while idle in S_HDR, saturates otherwise
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer <= '0;
    end else if (byte_ok || state_next == S_HDR) begin
      timer <= '0;
    end else if (timer != T_SAT) begin
      timer <= timer + 1'b1;
    end
  end

  // Frame capture, running CRC, shadow/output staging and status flags
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      crc_q          <= 8'h00;
      d0_q           <= 8'h00;
      d1_q           <= 8'h00;
      shadow         <= CH_RESET;
      ch_out         <= CH_RESET;
      pending        <= 1'b0;
      need_data      <= 1'b1;
      incorrect_data <= 1'b0;
      frame_ok       <= 1'b0;
      sync_prev      <= 1'b0;
    end else begin
      sync_prev <= sync_in;
      frame_ok  <= frame_good;
      ch_out    <= ch_next;
      pending   <= pending_next;
      need_data <= !pending_next;
      if (byte_ok) begin
        case (state)
          S_HDR: if (rx_byte == HEADER) crc_q <= crc_step;
          S_D0: begin
            d0_q  <= rx_byte;
            crc_q <= crc_step;
          end
          S_D1: begin
            d1_q  <= rx_byte;
            crc_q <= crc_step;
          end
          default: ;
        endcase
      end
      if (frame_good) shadow <= pattern;
      if (frame_good)                  incorrect_data <= 1'b0;
      else if (frame_bad || abort_err) incorrect_data <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_channel_frame_sequencer.sv
// ============================================================================
// Module      : tb_channel_frame_sequencer
// Description : Self-checking bench for channel_frame_sequencer. Directed
//               scenarios followed by randomized frames, compared every cycle
//               against a queue-based frame reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_channel_frame_sequencer;

  localparam int         T   = 16;
  localparam logic [7:0] HDR = 8'hA5;

  logic        CLK = 1'b0;
  logic        RST;
  logic        sync_in;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_error;
  logic [11:0] ch_out;
  logic        need_data;
  logic        incorrect_data;
  logic        frame_ok;

  int n_checks = 0;
  int n_fail   = 0;
  bit rand_sync = 1'b0;

  // reference model state
  logic [7:0]  q[$];
  logic [11:0] m_ch, m_shadow;
  bit          m_pend, m_inc, m_fok, m_prev;
  int          m_gap;

  always #5 CLK = ~CLK;

  channel_frame_sequencer #(
    .HEADER         (HDR),
    .TIMEOUT_CYCLES (T),
    .CH_RESET       (12'h000)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .sync_in        (sync_in),
    .rx_valid       (rx_valid),
    .rx_byte        (rx_byte),
    .rx_error       (rx_error),
    .ch_out         (ch_out),
    .need_data      (need_data),
    .incorrect_data (incorrect_data),
    .frame_ok       (frame_ok)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // CRC-8/0x07 as polynomial long division of the message with 8 zero bits appended
  function automatic logic [7:0] ref_crc(input logic [7:0] a, input logic [7:0] b,
                                         input logic [7:0] c);
    logic [31:0] m;
    m = {a, b, c, 8'h00};
    for (int i = 31; i >= 8; i--) begin
      if (m[i]) m[i -: 9] = m[i -: 9] ^ 9'h107;
    end
    return m[7:0];
  endfunction

  task automatic model_step();
    bit          edge_s;
    bit          good;
    logic [11:0] pat;
    logic [7:0]  d1;
    edge_s = sync_in && !m_prev;
    m_prev = sync_in;
    good   = 1'b0;
    pat    = '0;
    if (rx_error) begin
      if (q.size() > 0) m_inc = 1'b1;
      q.delete();
      m_gap = 0;
    end else if (rx_valid) begin
      m_gap = 0;
      if (q.size() > 0 || rx_byte == HDR) q.push_back(rx_byte);
      if (q.size() == 4) begin
        d1 = q[2];
        if (q[3] == ref_crc(q[0], q[1], q[2]) && d1[7:4] == 4'h0) begin
          good = 1'b1;
          pat  = {d1[3:0], q[1]};
        end else begin
          m_inc = 1'b1;
        end
        q.delete();
      end
    end else if (q.size() > 0) begin
      m_gap++;
      if (m_gap == T) begin
        m_inc = 1'b1;
        q.delete();
        m_gap = 0;
      end
    end
    if (good) m_inc = 1'b0;
    m_fok = good;
    if (good) m_shadow = pat;
    if (good && edge_s) begin
      m_ch   = pat;
      m_pend = 1'b0;
    end else if (good) begin
      m_pend = 1'b1;
    end else if (edge_s && m_pend) begin
      m_ch   = m_shadow;
      m_pend = 1'b0;
    end
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, "ch_out"},   32'(ch_out),         32'(m_ch));
    check({pfx, "need"},     32'(need_data),      32'(!m_pend));
    check({pfx, "incorrect"},32'(incorrect_data), 32'(m_inc));
    check({pfx, "frame_ok"}, 32'(frame_ok),       32'(m_fok));
  endtask

  task automatic tick();
    if (rand_sync && $urandom_range(0, 3) == 0) sync_in = ~sync_in;
    @(posedge CLK);
    model_step();
    #1;
    compare_all("");
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #2;
    q.delete();
    m_gap = 0; m_ch = 12'h000; m_shadow = 12'h000;
    m_pend = 1'b0; m_inc = 1'b0; m_fok = 1'b0; m_prev = 1'b0;
    compare_all("rst_");
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] crc_xor);
    send(HDR);
    send(d0);
    send(d1);
    send(ref_crc(HDR, d0, d1) ^ crc_xor);
  endtask

  task automatic sync_rise();
    sync_in = 1'b1;
    tick();
    sync_in = 1'b0;
  endtask

  task automatic rgap();
    idle($urandom_range(0, 3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d0, d1;
    RST = 1'b1; sync_in = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; rx_error = 1'b0;
    do_reset();

    // idle after reset
    idle(3);
    check("idle_ch", 32'(ch_out), 32'h000);
    check("idle_need", 32'(need_data), 32'd1);
    check("idle_inc", 32'(incorrect_data), 32'd0);

    // valid frame then sync commit
    send_frame(8'h3C, 8'h05, 8'h00);
    check("A_frame_ok", 32'(frame_ok), 32'd1);
    check("A_need", 32'(need_data), 32'd0);
    check("A_ch_held", 32'(ch_out), 32'h000);
    idle(2);
    sync_rise();
    check("A_ch", 32'(ch_out), 32'h53C);
    check("A_need_after", 32'(need_data), 32'd1);
    idle(1);

    // corrupted CRC rejected, next valid frame clears error
    send_frame(8'hFF, 8'h0F, 8'h01);
    check("B_inc", 32'(incorrect_data), 32'd1);
    check("B_fok", 32'(frame_ok), 32'd0);
    sync_rise();
    check("B_ch_unchanged", 32'(ch_out), 32'h53C);
    send_frame(8'h00, 8'h01, 8'h00);
    check("C_inc_clear", 32'(incorrect_data), 32'd0);
    sync_rise();
    check("C_ch", 32'(ch_out), 32'h100);

    // junk bytes ignored silently; reserved nibble rejected
    send(8'h00);
    send(8'h7E);
    check("junk_inc", 32'(incorrect_data), 32'd0);
    send_frame(8'h12, 8'h30, 8'h00);
    check("rsv_inc", 32'(incorrect_data), 32'd1);
    check("rsv_fok", 32'(frame_ok), 32'd0);
    send_frame(8'h34, 8'h02, 8'h00);
    check("D_fok", 32'(frame_ok), 32'd1);

    // gap of T-1 idle cycles is still inside the window
    send(HDR); send(8'h12); idle(T - 1);
    check("gap_inc", 32'(incorrect_data), 32'd0);
    send(8'h05); send(ref_crc(HDR, 8'h12, 8'h05));
    check("gap_fok", 32'(frame_ok), 32'd1);

    // timeout abort, then a fresh frame is accepted
    send(HDR); send(8'h12); idle(T + 1);
    check("to_inc", 32'(incorrect_data), 32'd1);
    send_frame(8'hAA, 8'h0B, 8'h00);
    check("to_recover_fok", 32'(frame_ok), 32'd1);
    check("to_recover_inc", 32'(incorrect_data), 32'd0);
    sync_rise();
    check("to_ch", 32'(ch_out), 32'hBAA);

    // frame completes in the same cycle as a sync edge
    send(HDR); send(8'h5A); send(8'h06);
    rx_valid = 1'b1; rx_byte = ref_crc(HDR, 8'h5A, 8'h06); sync_in = 1'b1;
    tick();
    rx_valid = 1'b0; sync_in = 1'b0;
    check("sim_ch", 32'(ch_out), 32'h65A);
    check("sim_need", 32'(need_data), 32'd1);
    idle(1);

    // reset in mid-frame; trailing bytes must not form a frame
    send(HDR); send(8'h55);
    do_reset();
    check("mrst_ch", 32'(ch_out), 32'h000);
    send(8'h0A); send(ref_crc(HDR, 8'h55, 8'h0A));
    check("mrst_fok", 32'(frame_ok), 32'd0);
    idle(2);

    // randomized traffic with random sync activity
    rand_sync = 1'b1;
    for (int it = 0; it < 300; it++) begin
      d0 = 8'($urandom);
      d1 = {4'h0, 4'($urandom)};
      case ($urandom_range(0, 7))
        0, 1, 2, 3: begin
          send(HDR); rgap(); send(d0); rgap(); send(d1); rgap();
          send(ref_crc(HDR, d0, d1));
        end
        4: send_frame(d0, d1, 8'(1 << $urandom_range(0, 7)));
        5: send_frame(d0, d1 | 8'h40, 8'h00);
        6: send(8'($urandom));
        default: begin
          send(HDR);
          if ($urandom_range(0, 1) == 1) send(d0);
          rx_error = 1'b1;
          rx_valid = 1'($urandom_range(0, 1));
          rx_byte  = 8'($urandom);
          tick();
          rx_error = 1'b0;
          rx_valid = 1'b0;
        end
      endcase
      rgap();
    end
    rand_sync = 1'b0;
    sync_in = 1'b0;
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
